// File: rtl/uart_cnt_pkg.sv
// Shared encodings and limits for the UART oversampling frame counters.
package uart_cnt_pkg;

   localparam int unsigned MIN_PRESCALE  = 4;
   localparam int unsigned MIN_DATA_BITS = 5;
   localparam int unsigned DLEN_W        = 4;

   localparam logic [1:0] FLD_START  = 2'b00;
   localparam logic [1:0] FLD_DATA   = 2'b01;
   localparam logic [1:0] FLD_PARITY = 2'b10;
   localparam logic [1:0] FLD_STOP   = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/uart_sample_strobe.sv
// Mid-bit 3-point sample strobe and last-edge flag from an edge index.
module uart_sample_strobe
   import uart_cnt_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic [PRESCALE_W-1:0] edge_cnt,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic                  sample_stb,
   output logic                  bit_end
);

   localparam int unsigned CMP_W = PRESCALE_W + 1;

   logic [CMP_W-1:0] edge_w;
   logic [CMP_W-1:0] pre_w;
   logic [CMP_W-1:0] mid_w;

   // Compare one bit wider and add to the edge side so nothing underflows.
   always_comb begin
      edge_w     = CMP_W'(edge_cnt);
      pre_w      = CMP_W'(Prescale);
      mid_w      = CMP_W'(Prescale >> 1);
      sample_stb = ((edge_w + CMP_W'(1)) >= mid_w) && (edge_w <= (mid_w + CMP_W'(1)));
      bit_end    = ((edge_w + CMP_W'(1)) == pre_w);
   end

endmodule

// File: rtl/uart_rx_frame_counter.sv
// Parametrised edge/bit counter for the UART RX path with field tags and frame/abort pulses.
module uart_rx_frame_counter
   import uart_cnt_pkg::*;
#(
   parameter int unsigned PRESCALE_W    = 6,
   parameter int unsigned MAX_DATA_BITS = 9,
   parameter int unsigned BIT_CNT_W     = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  enable,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic [DLEN_W-1:0]     data_len,
   input  logic                  stop2,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic [1:0]            field,
   output logic                  sample_stb,
   output logic                  bit_end,
   output logic                  frame_done,
   output logic                  abort,
   output logic                  cfg_err
);

   localparam int unsigned CMP_W = PRESCALE_W + 1;

   state_t                  state_q, state_d;
   logic [PRESCALE_W-1:0]   edge_d;
   logic [BIT_CNT_W-1:0]    bit_d;
   logic [PRESCALE_W-1:0]   presc_q, presc_d;
   logic [DLEN_W-1:0]       len_q, len_d;
   logic                    par_q, par_d;
   logic                    stop2_q, stop2_d;
   logic                    abort_d;
   logic                    cfg_err_d;
   logic                    cfg_ok;
   logic                    latch;
   logic                    run;
   logic                    stb_raw;
   logic                    be_raw;
   logic [BIT_CNT_W-1:0]    last_bit;

   uart_sample_strobe #(
      .PRESCALE_W (PRESCALE_W)
   ) u_strobe (
      .edge_cnt   (edge_cnt),
      .Prescale   (presc_q),
      .sample_stb (stb_raw),
      .bit_end    (be_raw)
   );

   // Frame-level decode from the latched config and counter state.
   always_comb begin
      run        = (state_q == ST_RUN);
      cfg_ok     = (CMP_W'(Prescale) >= CMP_W'(MIN_PRESCALE)) &&
                   (data_len >= DLEN_W'(MIN_DATA_BITS)) &&
                   (data_len <= DLEN_W'(MAX_DATA_BITS));
      last_bit   = BIT_CNT_W'(len_q) + BIT_CNT_W'(par_q) +
                   (stop2_q ? BIT_CNT_W'(2) : BIT_CNT_W'(1));
      sample_stb = run && stb_raw;
      bit_end    = run && be_raw;
      frame_done = run && be_raw && (bit_cnt == last_bit);
      if (!run || (bit_cnt == '0)) begin
         field = FLD_START;
      end else if (bit_cnt <= BIT_CNT_W'(len_q)) begin
         field = FLD_DATA;
      end else if (par_q && (bit_cnt == (BIT_CNT_W'(len_q) + BIT_CNT_W'(1)))) begin
         field = FLD_PARITY;
      end else begin
         field = FLD_STOP;
      end
   end

   // Next-state, counter and config-latch logic.
   always_comb begin
      state_d   = state_q;
      edge_d    = edge_cnt;
      bit_d     = bit_cnt;
      abort_d   = 1'b0;
      cfg_err_d = cfg_err;
      latch     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            edge_d = '0;
            bit_d  = '0;
            if (enable) begin
               if (cfg_ok) begin
                  state_d   = ST_RUN;
                  latch     = 1'b1;
                  cfg_err_d = 1'b0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end else begin
               cfg_err_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d   = ST_IDLE;
               edge_d    = '0;
               bit_d     = '0;
               cfg_err_d = 1'b0;
               abort_d   = !frame_done;
            end else if (be_raw) begin
               edge_d = '0;
               if (bit_cnt == last_bit) begin
                  bit_d = '0;
                  if (cfg_ok) begin
                     latch     = 1'b1;
                     cfg_err_d = 1'b0;
                  end else begin
                     state_d   = ST_IDLE;
                     cfg_err_d = 1'b1;
                  end
               end else begin
                  bit_d = bit_cnt + BIT_CNT_W'(1);
               end
            end else begin
               edge_d = edge_cnt + PRESCALE_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      presc_d = latch ? Prescale : presc_q;
      len_d   = latch ? data_len : len_q;
      par_d   = latch ? PAR_EN   : par_q;
      stop2_d = latch ? stop2    : stop2_q;
   end

   // State, counters, latched config and registered flags.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= ST_IDLE;
         edge_cnt <= '0;
         bit_cnt  <= '0;
         presc_q  <= '0;
         len_q    <= '0;
         par_q    <= 1'b0;
         stop2_q  <= 1'b0;
         abort    <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state_q  <= state_d;
         edge_cnt <= edge_d;
         bit_cnt  <= bit_d;
         presc_q  <= presc_d;
         len_q    <= len_d;
         par_q    <= par_d;
         stop2_q  <= stop2_d;
         abort    <= abort_d;
         cfg_err  <= cfg_err_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Scoreboard bench for uart_rx_frame_counter: stimulus queues per-cycle expectations, monitor checks them.
module tb_uart_rx_frame_counter;
   import uart_cnt_pkg::*;

   localparam int unsigned PW = 6;
   localparam int unsigned BW = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          enable;
   logic [PW-1:0] Prescale;
   logic          PAR_EN;
   logic [3:0]    data_len;
   logic          stop2;
   logic [PW-1:0] edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic [1:0]    field;
   logic          sample_stb, bit_end, frame_done, abort, cfg_err;

   typedef struct packed {
      int            cyc;
      int            tid;
      int            kind;
      logic [PW-1:0] e;
      logic [BW-1:0] b;
      logic [1:0]    f;
      logic          stb, be, fd, ab, ce;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   fd_seen = 0;
   int   ab_seen = 0;
   int   fd_exp  = 0;
   int   ab_exp  = 0;

   uart_rx_frame_counter dut (
      .CLK        (CLK),
      .RST        (RST),
      .enable     (enable),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .data_len   (data_len),
      .stop2      (stop2),
      .edge_cnt   (edge_cnt),
      .bit_cnt    (bit_cnt),
      .field      (field),
      .sample_stb (sample_stb),
      .bit_end    (bit_end),
      .frame_done (frame_done),
      .abort      (abort),
      .cfg_err    (cfg_err)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   // Reference for the n-th RUN cycle (1-based) of a frame with the given config.
   function automatic exp_t mk_run(int c, int tid, int n, int p, int len, int par, int s2);
      exp_t r;
      int   l, e, b, mid;
      l   = 1 + len + par + (s2 != 0 ? 2 : 1);
      e   = (n - 1) % p;
      b   = ((n - 1) / p) % l;
      mid = p / 2;
      r.cyc  = c;
      r.tid  = tid;
      r.kind = 0;
      r.e    = PW'(e);
      r.b    = BW'(b);
      if (b == 0)                         r.f = 2'b00;
      else if (b <= len)                  r.f = 2'b01;
      else if (par != 0 && b == len + 1)  r.f = 2'b10;
      else                                r.f = 2'b11;
      r.stb = (e >= mid - 1) && (e <= mid + 1);
      r.be  = (e == p - 1);
      r.fd  = (e == p - 1) && (b == l - 1);
      r.ab  = 1'b0;
      r.ce  = 1'b0;
      return r;
   endfunction

   function automatic exp_t mk_idle(int c, int tid, logic ab, logic ce);
      exp_t r;
      r = '0;
      r.cyc  = c;
      r.tid  = tid;
      r.kind = 2;
      r.ab   = ab;
      r.ce   = ce;
      return r;
   endfunction

   function automatic exp_t mk_hand(int c, int tid, int e, int b, logic [1:0] f,
                                    logic stb, logic be, logic fd);
      exp_t r;
      r = '0;
      r.cyc  = c;
      r.tid  = tid;
      r.kind = 1;
      r.e    = PW'(e);
      r.b    = BW'(b);
      r.f    = f;
      r.stb  = stb;
      r.be   = be;
      r.fd   = fd;
      return r;
   endfunction

   task automatic push_run(int k, int tid, int n_lo, int n_hi, int p, int len, int par, int s2);
      for (int n = n_lo; n <= n_hi; n++) sb.push_back(mk_run(k + n, tid, n, p, len, par, s2));
   endtask

   task automatic tick_to(int c);
      while (cyc < c) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Monitor: compare every expectation due this cycle against the DUT outputs.
   always @(negedge CLK) begin
      logic [16:0] got, want;
      got = {edge_cnt, bit_cnt, field, sample_stb, bit_end, frame_done, abort, cfg_err};
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            want = {sb[i].e, sb[i].b, sb[i].f, sb[i].stb, sb[i].be, sb[i].fd, sb[i].ab, sb[i].ce};
            n_cmp++;
            if (sb[i].cyc < cyc || got !== want) begin
               n_bad++;
               $display("FAIL t%0d_k%0d cyc=%0d got e=%0d b=%0d f=%0d stb=%b be=%b fd=%b ab=%b ce=%b want e=%0d b=%0d f=%0d stb=%b be=%b fd=%b ab=%b ce=%b",
                        sb[i].tid, sb[i].kind, cyc, edge_cnt, bit_cnt, field, sample_stb, bit_end,
                        frame_done, abort, cfg_err, sb[i].e, sb[i].b, sb[i].f, sb[i].stb, sb[i].be,
                        sb[i].fd, sb[i].ab, sb[i].ce);
            end
            sb.delete(i);
         end
      end
      if (frame_done === 1'b1) fd_seen++;
      if (abort === 1'b1)      ab_seen++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
      $fatal(1, "timeout");
   end

   initial begin
      int k, k2, k3, j, kb, kc;
      RST = 1'b0; enable = 1'b0; Prescale = 6'd8; data_len = 4'd8; PAR_EN = 1'b0; stop2 = 1'b0;
      sb.push_back(mk_idle(1, 0, 1'b0, 1'b0));
      sb.push_back(mk_idle(2, 0, 1'b0, 1'b0));
      tick_to(3);
      RST = 1'b1;
      sb.push_back(mk_idle(4, 0, 1'b0, 1'b0));
      tick_to(5);

      // T1: 8N1 at Prescale 8, two back-to-back frames, then stop at frame end.
      k = cyc; enable = 1'b1;
      push_run(k, 1, 1, 160, 8, 8, 0, 0);
      sb.push_back(mk_hand(k + 3,   1, 2, 0, FLD_START, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk_hand(k + 4,   1, 3, 0, FLD_START, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk_hand(k + 6,   1, 5, 0, FLD_START, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk_hand(k + 7,   1, 6, 0, FLD_START, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk_hand(k + 80,  1, 7, 9, FLD_STOP,  1'b0, 1'b1, 1'b1));
      sb.push_back(mk_hand(k + 81,  1, 0, 0, FLD_START, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk_hand(k + 160, 1, 7, 9, FLD_STOP,  1'b0, 1'b1, 1'b1));
      fd_exp += 2;
      tick_to(k + 160);
      enable = 1'b0;
      sb.push_back(mk_idle(k + 161, 1, 1'b0, 1'b0));
      sb.push_back(mk_idle(k + 162, 1, 1'b0, 1'b0));
      tick_to(k + 163);

      // T2: 7 data, parity, 2 stops at Prescale 16; config changed mid-frame.
      k = cyc; Prescale = 6'd16; data_len = 4'd7; PAR_EN = 1'b1; stop2 = 1'b1; enable = 1'b1;
      push_run(k, 2, 1, 176, 16, 7, 1, 1);
      sb.push_back(mk_hand(k + 129, 2, 0,  8,  FLD_PARITY, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk_hand(k + 136, 2, 7,  8,  FLD_PARITY, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk_hand(k + 145, 2, 0,  9,  FLD_STOP,   1'b0, 1'b0, 1'b0));
      sb.push_back(mk_hand(k + 161, 2, 0,  10, FLD_STOP,   1'b0, 1'b0, 1'b0));
      sb.push_back(mk_hand(k + 176, 2, 15, 10, FLD_STOP,   1'b0, 1'b1, 1'b1));
      fd_exp += 1;
      tick_to(k + 100);
      Prescale = 6'd5; data_len = 4'd5; PAR_EN = 1'b0; stop2 = 1'b0;

      // T3: odd Prescale 5 picked up at the frame boundary, L = 7.
      k2 = k + 176;
      push_run(k2, 3, 1, 35, 5, 5, 0, 0);
      sb.push_back(mk_hand(k2 + 1,  3, 0, 0, FLD_START, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk_hand(k2 + 2,  3, 1, 0, FLD_START, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk_hand(k2 + 4,  3, 3, 0, FLD_START, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk_hand(k2 + 5,  3, 4, 0, FLD_START, 1'b0, 1'b1, 1'b0));
      sb.push_back(mk_hand(k2 + 35, 3, 4, 6, FLD_STOP,  1'b0, 1'b1, 1'b1));
      fd_exp += 1;
      tick_to(k2 + 10);
      Prescale = 6'd8; data_len = 4'd8;

      // T4: drop enable at bit 3 edge 2 of the next frame.
      k3 = k2 + 35;
      push_run(k3, 4, 1, 27, 8, 8, 0, 0);
      sb.push_back(mk_hand(k3 + 27, 4, 2, 3, FLD_DATA, 1'b0, 1'b0, 1'b0));
      tick_to(k3 + 27);
      enable = 1'b0;
      sb.push_back(mk_idle(k3 + 28, 4, 1'b1, 1'b0));
      sb.push_back(mk_idle(k3 + 29, 4, 1'b0, 1'b0));
      sb.push_back(mk_idle(k3 + 30, 4, 1'b0, 1'b0));
      ab_exp += 1;
      tick_to(k3 + 30);

      // T5: illegal starts (Prescale 3, then data_len 10), then a legal start.
      j = cyc; Prescale = 6'd3; data_len = 4'd8; enable = 1'b1;
      sb.push_back(mk_idle(j + 1, 5, 1'b0, 1'b1));
      sb.push_back(mk_idle(j + 2, 5, 1'b0, 1'b1));
      tick_to(j + 2);
      enable = 1'b0;
      sb.push_back(mk_idle(j + 3, 5, 1'b0, 1'b0));
      tick_to(j + 3);
      Prescale = 6'd8; data_len = 4'd10; enable = 1'b1;
      sb.push_back(mk_idle(j + 4, 5, 1'b0, 1'b1));
      tick_to(j + 4);
      data_len = 4'd8;

      // T6: data_len 8 -> 5 mid-frame takes effect on the next frame only.
      k = j + 4;
      push_run(k, 6, 1, 80, 8, 8, 0, 0);
      sb.push_back(mk_hand(k + 80, 6, 7, 9, FLD_STOP, 1'b0, 1'b1, 1'b1));
      tick_to(k + 40);
      data_len = 4'd5;
      kb = k + 80;
      push_run(kb, 6, 1, 56, 8, 5, 0, 0);
      sb.push_back(mk_hand(kb + 56, 6, 7, 6, FLD_STOP, 1'b0, 1'b1, 1'b1));
      fd_exp += 2;

      // T7: reset in the middle of the following frame.
      kc = kb + 56;
      push_run(kc, 7, 1, 18, 8, 5, 0, 0);
      tick_to(kc + 19);
      RST = 1'b0;
      sb.push_back(mk_idle(kc + 19, 7, 1'b0, 1'b0));
      sb.push_back(mk_idle(kc + 20, 7, 1'b0, 1'b0));
      tick_to(kc + 20);
      enable = 1'b0;
      RST = 1'b1;
      sb.push_back(mk_idle(kc + 21, 7, 1'b0, 1'b0));
      sb.push_back(mk_idle(kc + 22, 7, 1'b0, 1'b0));
      tick_to(kc + 23);

      // Pulse totals catch spurious frame_done/abort between checked cycles.
      n_cmp++;
      if (fd_seen != fd_exp) begin
         n_bad++;
         $display("FAIL frame_done_count got=%0d want=%0d", fd_seen, fd_exp);
      end
      n_cmp++;
      if (ab_seen != ab_exp) begin
         n_bad++;
         $display("FAIL abort_count got=%0d want=%0d", ab_seen, ab_exp);
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
